// File: rtl/keypad_time_loader.sv
// Keypad receiver: debounces one-hot key presses and shifts each accepted
// digit into a 3-digit BCD cook time (min : sec_tens sec_ones).
module keypad_time_loader #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int CNT_W           = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [9:0] keys,
  input  logic       clearn,
  input  logic       load_en,
  output logic [3:0] min_bcd,
  output logic [3:0] sec_tens_bcd,
  output logic [3:0] sec_ones_bcd,
  output logic       key_strobe,
  output logic       time_nonzero
);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [9:0]       keys_q;
  logic [9:0]       cand_q, cand_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       min_q, min_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             strobe_q, strobe_d;
  logic             nz_q, nz_d;

  logic             keys_any;
  logic             keys_onehot;
  logic             accept;
  logic [3:0]       cand_bcd;

  // x & (x-1) clears the lowest set bit; zero result means at most one bit set
  assign keys_any    = |keys_q;
  assign keys_onehot = keys_any && ((keys_q & (keys_q - 10'd1)) == 10'd0);

  always_comb begin
    cand_bcd = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (cand_q[k]) cand_bcd = 4'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (keys_onehot) begin
          cand_d  = keys_q;
          cnt_d   = CNT_ONE;
          state_d = PRESS;
        end else if (keys_any) begin
          state_d = HELD;
        end
      end
      PRESS: begin
        if (keys_q != cand_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          accept  = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!keys_any) begin
          cnt_d   = CNT_ONE;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (keys_any) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear beats accept; the FSM still consumes the press so it is not retried.
  always_comb begin
    min_d    = min_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    strobe_d = 1'b0;
    if (!clearn) begin
      min_d  = 4'd0;
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (accept && load_en) begin
      min_d    = tens_q;
      tens_d   = ones_q;
      ones_d   = cand_bcd;
      strobe_d = 1'b1;
    end
    nz_d = |{min_q, tens_q, ones_q};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      keys_q   <= '0;
      cand_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      min_q    <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      strobe_q <= 1'b0;
      nz_q     <= 1'b0;
    end else begin
      keys_q   <= keys;
      cand_q   <= cand_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      min_q    <= min_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      strobe_q <= strobe_d;
      nz_q     <= nz_d;
    end
  end

  assign min_bcd      = min_q;
  assign sec_tens_bcd = tens_q;
  assign sec_ones_bcd = ones_q;
  assign key_strobe   = strobe_q;
  assign time_nonzero = nz_q;

endmodule

// File: tb/tb_keypad_time_loader.sv
// Bench for keypad_time_loader: per-cycle comparison against a cook-time
// model, table-driven entry sequence, directed corner cases, random presses.
module tb_keypad_time_loader;
  localparam int DEB = 3;

  logic       clock = 1'b0;
  logic       resetn;
  logic [9:0] keys;
  logic       clearn;
  logic       load_en;
  logic [3:0] min_bcd, sec_tens_bcd, sec_ones_bcd;
  logic       key_strobe, time_nonzero;

  keypad_time_loader #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clock(clock), .resetn(resetn), .keys(keys), .clearn(clearn),
    .load_en(load_en), .min_bcd(min_bcd), .sec_tens_bcd(sec_tens_bcd),
    .sec_ones_bcd(sec_ones_bcd), .key_strobe(key_strobe),
    .time_nonzero(time_nonzero)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0, strobes = 0;

  // model: cook time kept as an integer 0..999; mode 0 ready, 1 counting a
  // press, 2 locked until DEB consecutive released samples
  logic [9:0] m_kq, m_cand;
  int         m_mode, m_run, m_time;
  bit         m_stb, m_nz;

  typedef struct { logic [9:0] key; int exp_time; } seg_t;
  seg_t tbl[8];

  function automatic logic [9:0] key_of(input int d);
    logic [9:0] one;
    one = 10'd1;
    return one << d;
  endfunction

  function automatic int dut_vec();
    return int'({min_bcd, sec_tens_bcd, sec_ones_bcd, key_strobe, time_nonzero});
  endfunction

  function automatic int exp_vec();
    return ((m_time / 100) << 10) | (((m_time / 10) % 10) << 6) |
           ((m_time % 10) << 2) | (int'(m_stb) << 1) | int'(m_nz);
  endfunction

  function automatic int cur_time();
    return int'(min_bcd) * 100 + int'(sec_tens_bcd) * 10 + int'(sec_ones_bcd);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_kq = '0; m_cand = '0; m_mode = 0; m_run = 0; m_time = 0;
    m_stb = 1'b0; m_nz = 1'b0;
  endtask

  task automatic model_edge(input logic [9:0] k, input bit ld, input bit cl);
    bit acc;
    int d;
    acc = 1'b0;
    d = 0;
    m_nz = (m_time != 0);
    if (m_mode == 0) begin
      if ($countones(m_kq) == 1) begin m_mode = 1; m_cand = m_kq; m_run = 1; end
      else if (m_kq != 0) begin m_mode = 2; m_run = 0; end
    end else if (m_mode == 1) begin
      if (m_kq == m_cand) begin
        m_run++;
        if (m_run == DEB) begin acc = 1'b1; m_mode = 2; m_run = 0; end
      end else m_mode = 0;
    end else begin
      if (m_kq == 0) begin
        m_run++;
        if (m_run == DEB) m_mode = 0;
      end else m_run = 0;
    end
    for (int i = 0; i < 10; i++) if (m_cand[i]) d = i;
    m_stb = 1'b0;
    if (!cl) m_time = 0;
    else if (acc && ld) begin m_time = (m_time * 10 + d) % 1000; m_stb = 1'b1; end
    m_kq = k;
  endtask

  task automatic step(input logic [9:0] k, input bit ld, input bit cl);
    keys = k; load_en = ld; clearn = cl;
    @(posedge clock);
    model_edge(k, ld, cl);
    #1;
    if (key_strobe) strobes++;
    check("cycle", dut_vec(), exp_vec());
  endtask

  task automatic run_seg(input logic [9:0] k, input int on, input int off);
    for (int i = 0; i < on; i++) step(k, 1'b1, 1'b1);
    for (int i = 0; i < off; i++) step('0, 1'b1, 1'b1);
  endtask

  initial begin
    int s0, hit_at, r, n;
    logic [9:0] k;
    bit ld;
    resetn = 1'b0; keys = '0; clearn = 1'b1; load_en = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) tbl[i].key = key_of(1);
    tbl[6].key = key_of(2);
    tbl[7].key = key_of(8);
    tbl[0].exp_time = 1;   tbl[1].exp_time = 11;  tbl[2].exp_time = 111;
    tbl[3].exp_time = 111; tbl[4].exp_time = 111; tbl[5].exp_time = 111;
    tbl[6].exp_time = 112; tbl[7].exp_time = 128;
    #12;
    check("reset_state", dut_vec(), 0);
    resetn = 1'b1;

    // 1: six 1s, then 2, then 8 -> 1:28
    s0 = strobes;
    for (int i = 0; i < 8; i++) begin
      n = strobes;
      run_seg(tbl[i].key, 5, 15);
      check("t1_seg_strobe", strobes - n, 1);
      check("t1_seg_time", cur_time(), tbl[i].exp_time);
    end
    check("t1_total_strobes", strobes - s0, 8);
    check("t1_nonzero", int'(time_nonzero), 1);

    // 2: short bounce rejected, then exact accept latency
    s0 = strobes;
    run_seg(key_of(3), DEB - 1, 10);
    check("t2_short_strobe", strobes - s0, 0);
    check("t2_short_time", cur_time(), 128);
    hit_at = -1;
    for (int i = 0; i < 40; i++) begin
      step(key_of(3), 1'b1, 1'b1);
      if (key_strobe) hit_at = i;
    end
    check("t2_latency", hit_at, DEB);
    run_seg('0, 0, 10);
    check("t2_strobes", strobes - s0, 1);
    check("t2_time", cur_time(), 283);

    // 3: multi-hot locked out, then 4
    s0 = strobes;
    run_seg(10'b0000100100, 10, 10);
    check("t3_multihot_strobe", strobes - s0, 0);
    run_seg(key_of(4), 5, 10);
    check("t3_strobes", strobes - s0, 1);
    check("t3_time", cur_time(), 834);

    // 4: release bounce gives no extra digit
    s0 = strobes;
    for (int i = 0; i < 5; i++) step(key_of(5), 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step((i % 2) ? key_of(5) : 10'd0, 1'b1, 1'b1);
    run_seg('0, 0, 10);
    run_seg(key_of(6), 5, 10);
    check("t4_strobes", strobes - s0, 2);
    check("t4_time", cur_time(), 456);

    // 5: load disabled at accept, enabling mid-hold does not load
    s0 = strobes;
    for (int i = 0; i < 5; i++) step(key_of(7), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(key_of(7), 1'b1, 1'b1);
    run_seg('0, 0, 10);
    check("t5_no_strobe", strobes - s0, 0);
    check("t5_time_kept", cur_time(), 456);
    run_seg(key_of(7), 5, 10);
    check("t5_new_press", cur_time(), 567);

    // 6: clear coinciding with accept, then reset mid-press
    step('0, 1'b1, 1'b0);
    run_seg(key_of(1), 5, 15);
    run_seg(key_of(2), 5, 15);
    run_seg(key_of(8), 5, 15);
    check("t6_setup", cur_time(), 128);
    s0 = strobes;
    for (int i = 0; i < DEB; i++) step(key_of(9), 1'b1, 1'b1);
    step(key_of(9), 1'b1, 1'b0);
    check("t6_clear_time", cur_time(), 0);
    check("t6_nz_lags", int'(time_nonzero), 1);
    step(key_of(9), 1'b1, 1'b1);
    check("t6_nz_falls", int'(time_nonzero), 0);
    run_seg(key_of(9), 4, 10);
    check("t6_no_strobe", strobes - s0, 0);
    check("t6_no_reaccept", cur_time(), 0);
    run_seg(key_of(7), 5, 10);
    step(key_of(3), 1'b1, 1'b1);
    step(key_of(3), 1'b1, 1'b1);
    resetn = 1'b0;
    #2;
    check("t6_async_reset", dut_vec(), 0);
    model_reset();
    #1 resetn = 1'b1;
    for (int i = 0; i < 10; i++) step(key_of(3), 1'b1, 1'b1);
    check("t6_held_after_reset", cur_time(), 3);
    run_seg('0, 0, 10);

    // random presses, bounces, multi-hot, load/clear toggling
    repeat (300) begin
      r = $urandom_range(0, 9);
      if (r < 6) k = key_of($urandom_range(0, 9));
      else if (r < 8) k = '0;
      else k = 10'($urandom);
      n = $urandom_range(1, 8);
      ld = ($urandom_range(0, 7) != 0);
      for (int j = 0; j < n; j++) step(k, ld, $urandom_range(0, 29) != 0);
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++) step('0, 1'b1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/keypad_time_loader.md
Name: keypad_time_loader

Overview:
- Receiving end of the microwave's keypad interface: accepts the 10-bit one-hot `keys` bus and turns presses into a 3-digit BCD cook time (minutes, seconds tens, seconds ones).
- Debounces each press, encodes it to BCD and shifts the digit in from the right. Pressing 1,2,8 yields 1:28.
- Sits between the keypad pins and the timer/display logic, which reads the digits and `key_strobe`.

Parameters:
- DEBOUNCE_CYCLES, 3: consecutive identical samples needed to accept a press and to accept a release. Legal range is 2..15.
- CNT_W, 4: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock, 100 Hz nominal, rising edge.
- resetn  in  1  asynchronous active-low reset.
- keys  in  10  keypad, one-hot; bit k means digit k; all zero means released.
- clearn  in  1  synchronous active-low digit clear (user CLEAR button).
- load_en  in  1  1 = entry allowed (magnetron off); 0 = presses are consumed but ignored.
- min_bcd  out  4  minutes digit.
- sec_tens_bcd  out  4  seconds tens digit.
- sec_ones_bcd  out  4  seconds ones digit.
- key_strobe  out  1  one-cycle pulse when a digit is shifted in.
- time_nonzero  out  1  registered OR of all three digits being nonzero.

Behaviour:
- Reset (resetn=0, asynchronous):
  - keys_q=0, all digits=0, key_strobe=0, time_nonzero=0.
  - FSM goes to IDLE; counter cleared.
- Input sampling: `keys` is registered once into keys_q. All decisions use keys_q.
- Valid press: keys_q has exactly one bit set. Multi-hot (two or more bits) is invalid.
- FSM states: IDLE, PRESS, HELD, RELEASE.
  - IDLE:
    - keys_q valid: cand<=keys_q, cnt<=1, go to PRESS.
    - keys_q multi-hot: go to HELD (lockout, no load).
    - keys_q==0: stay.
  - PRESS:
    - keys_q==cand and cnt==DEBOUNCE_CYCLES-1: accept, go to HELD.
    - keys_q==cand otherwise: cnt++.
    - keys_q!=cand: go to IDLE (bounce rejected, nothing loaded).
  - HELD:
    - keys_q==0: cnt<=1, go to RELEASE.
    - otherwise stay. Key changes while held are ignored.
  - RELEASE:
    - keys_q!=0: go to HELD.
    - keys_q==0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
    - keys_q==0 otherwise: cnt++.
- Accept action, registered, when load_en=1 and clearn=1:
  - min<=sec_tens, sec_tens<=sec_ones, sec_ones<=BCD(cand). Old min digit is discarded.
  - key_strobe=1 for exactly that one cycle.
- Latency: if `keys` holds a valid code from before edge E0 (the edge that first captures it into keys_q), digits and strobe update at edge E0+DEBOUNCE_CYCLES.
- Encoder: bit k maps to 4'dk, 0..9. Values are never normalized: a seconds tens digit above 5 is passed through as entered; range checking belongs to the timer.
- load_en=0 at the accept edge: FSM still goes to HELD; no shift, no strobe.
- clearn=0 (synchronous, highest priority over accept):
  - All digits go to 0; no strobe that cycle.
  - FSM and counter are unaffected, so a press held through clear is not re-accepted.
- One press gives exactly one digit, regardless of hold duration.
- The next press must be preceded by DEBOUNCE_CYCLES zero samples.
- time_nonzero updates one cycle after the digits (registered from the digit registers).
- resetn asserted mid-press: immediate return to reset values. A key still held after reset is treated as a new press.

Test Plan:
1. Reset, then press key bit1 (10'b0000000010) for 5 cycles and release for 15 cycles, six times; then bit2, then bit8 (5 cycles on / 15 off each) -> exactly 8 strobes; final min=1, sec_tens=2, sec_ones=8; time_nonzero=1.
2. Key bit3 asserted for only DEBOUNCE_CYCLES-1 samples, then 0 -> no strobe, digits unchanged. Then held for 40 cycles -> exactly one strobe at E0+3, sec_ones=3.
3. keys=10'b0000100100 (multi-hot) for 10 cycles, released, then bit4 pressed -> no load from the multi-hot; one load of 4.
4. Release bounce: hold bit5, then alternate 0/bit5 every cycle for 6 cycles, then 0 for 10 cycles, then press bit6 -> digits end as ...5,6 with one strobe each; no extra 5.
5. load_en=0 during a press of bit7 -> no strobe, digits unchanged. Set load_en=1 while still holding -> still no load until release and a new press.
6. Digits at 1:28, assert clearn=0 for 1 cycle coinciding with an accept edge of bit9 -> digits 0:00, no strobe, time_nonzero falls the next cycle. resetn pulsed mid-PRESS -> all outputs 0 immediately.
